// File: rtl/key_debounce_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg -- shared definitions for the push-button debouncer.
//
// Holds the debouncer FSM state enum and the default timing constants used
// as parameter defaults by key_debounce and ms_tick_gen.
// The optional auto-repeat feature is selected with macro KEY_REPEAT_EN.
// ---------------------------------------------------------------------------
package key_pkg;

  // Default timing: clk cycles per ms, and all other values in ms.
  localparam int CLK_PER_MS_DEF       = 44801;
  localparam int DEBOUNCE_MS_DEF      = 10;
  localparam int REPEAT_DELAY_MS_DEF  = 500;
  localparam int REPEAT_PERIOD_MS_DEF = 100;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // released and stable
    PRESS_CHK = 2'd1,  // key seen pressed, waiting for a stable level
    HELD      = 2'd2,  // press accepted
    REL_CHK   = 2'd3   // key seen released, waiting for a stable level
  } key_state_e;

endpackage

// File: rtl/key_debounce_if.sv
// ---------------------------------------------------------------------------
// key_debounce_if -- signal bundle between the debouncer and its user.
//
//   key_in    raw push-button level, 1 = pressed (driven by the user side)
//   ms_tick   one-clk pulse per millisecond
//   key_level debounced key state, 1 = pressed
//   key_pulse one-clk pulse per accepted press (plus repeats when enabled)
//
// Modports: master = user/stimulus side, slave = the debouncer.
// ---------------------------------------------------------------------------
interface key_debounce_if;
  logic key_in;
  logic ms_tick;
  logic key_level;
  logic key_pulse;

  modport master (output key_in, input ms_tick, key_level, key_pulse);
  modport slave  (input key_in, output ms_tick, key_level, key_pulse);
endinterface

// File: rtl/key_debounce_ms_tick_gen.sv
// ---------------------------------------------------------------------------
// ms_tick_gen -- millisecond prescaler.
//
// Counts 0..CLK_PER_MS-1 and wraps; ms_tick is high exactly on the cycle the
// count equals CLK_PER_MS-1.
//
// Ports:
//   clk      sole clock
//   rst      asynchronous, active-low reset
//   ms_tick  one-clk pulse every CLK_PER_MS cycles
// ---------------------------------------------------------------------------
module ms_tick_gen
  import key_pkg::*;
#(
  parameter int CLK_PER_MS = CLK_PER_MS_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic ms_tick
);

  localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Qualified with rst so the tick stays low during reset even when the
  // modulus is 1 (count 0 would otherwise already be the terminal count).
  assign ms_tick = rst && (cnt_reg == LAST);

endmodule

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce -- push-button debouncer with optional auto-repeat.
//
// key_in is synchronised by two flops, then a four-state FSM requires the
// level to stay stable for DEBOUNCE_MS millisecond ticks before a press or
// release is accepted. Each accepted press yields one key_pulse.
//
// Optional feature (macro KEY_REPEAT_EN): while held, one extra key_pulse
// after REPEAT_DELAY_MS ms and then one every REPEAT_PERIOD_MS ms. Without
// the macro the repeat logic is not built.
//
// Ports:
//   clk   sole clock, all state on posedge
//   rst   asynchronous, active-low reset
//   kbd   key_debounce_if.slave: key_in in; ms_tick, key_level, key_pulse out
// ---------------------------------------------------------------------------
module key_debounce
  import key_pkg::*;
#(
  parameter int CLK_PER_MS       = CLK_PER_MS_DEF,
  parameter int DEBOUNCE_MS      = DEBOUNCE_MS_DEF,
  parameter int REPEAT_DELAY_MS  = REPEAT_DELAY_MS_DEF,
  parameter int REPEAT_PERIOD_MS = REPEAT_PERIOD_MS_DEF
) (
  input logic          clk,
  input logic          rst,
  key_debounce_if.slave kbd
);

  // The counter must reach the largest ms threshold in use.
  localparam int MAX_DR  = (DEBOUNCE_MS > REPEAT_DELAY_MS) ? DEBOUNCE_MS : REPEAT_DELAY_MS;
  localparam int CNT_MAX = (MAX_DR > REPEAT_PERIOD_MS) ? MAX_DR : REPEAT_PERIOD_MS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE_MS);

  logic ms_tick;
  logic sync1_reg;
  logic key_s;

  key_state_e    state_reg, state_next;
  logic [CW-1:0] ms_cnt_reg, ms_cnt_next;
  logic [CW-1:0] ms_cnt_inc;
  logic          level_reg, level_next;
  logic          pulse_reg, pulse_next;

  ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .ms_tick(ms_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      key_s     <= 1'b0;
    end else begin
      sync1_reg <= kbd.key_in;
      key_s     <= sync1_reg;
    end
  end

  assign ms_cnt_inc = ms_cnt_reg + 1'b1;

`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] DLY_C = CW'(REPEAT_DELAY_MS);
  localparam logic [CW-1:0] PER_C = CW'(REPEAT_PERIOD_MS);
  // 0 = waiting for the first repeat, 1 = in the periodic phase.
  logic          rep_phase_reg, rep_phase_next;
  logic [CW-1:0] rep_limit;
  assign rep_limit = rep_phase_reg ? PER_C : DLY_C;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_phase_reg <= 1'b0;
    else      rep_phase_reg <= rep_phase_next;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      ms_cnt_reg <= '0;
      level_reg  <= 1'b0;
      pulse_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ms_cnt_reg <= ms_cnt_next;
      level_reg  <= level_next;
      pulse_reg  <= pulse_next;
    end
  end

  // A change of key_s always takes priority over a coincident ms_tick.
  always_comb begin
    state_next  = state_reg;
    ms_cnt_next = ms_cnt_reg;
    level_next  = level_reg;
    pulse_next  = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_phase_next = rep_phase_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (key_s) begin
          state_next  = PRESS_CHK;
          ms_cnt_next = '0;
        end
      end
      PRESS_CHK: begin
        if (!key_s) begin
          state_next  = IDLE;
          ms_cnt_next = '0;
        end else if (ms_tick) begin
          if (ms_cnt_inc == DEB_C) begin
            state_next  = HELD;
            ms_cnt_next = '0;
            level_next  = 1'b1;
            pulse_next  = 1'b1;
`ifdef KEY_REPEAT_EN
            rep_phase_next = 1'b0;
`endif
          end else begin
            ms_cnt_next = ms_cnt_inc;
          end
        end
      end
      HELD: begin
        if (!key_s) begin
          state_next  = REL_CHK;
          ms_cnt_next = '0;
        end
`ifdef KEY_REPEAT_EN
        else if (ms_tick) begin
          if (ms_cnt_inc == rep_limit) begin
            ms_cnt_next    = '0;
            pulse_next     = 1'b1;
            rep_phase_next = 1'b1;
          end else begin
            ms_cnt_next = ms_cnt_inc;
          end
        end
`endif
      end
      REL_CHK: begin
        if (key_s) begin
          // Release was a bounce: back to HELD with the repeat timer restarted.
          state_next  = HELD;
          ms_cnt_next = '0;
`ifdef KEY_REPEAT_EN
          rep_phase_next = 1'b0;
`endif
        end else if (ms_tick) begin
          if (ms_cnt_inc == DEB_C) begin
            state_next  = IDLE;
            ms_cnt_next = '0;
            level_next  = 1'b0;
          end else begin
            ms_cnt_next = ms_cnt_inc;
          end
        end
      end
      default: begin
        state_next  = IDLE;
        ms_cnt_next = '0;
      end
    endcase
  end

  assign kbd.ms_tick   = ms_tick;
  assign kbd.key_level = level_reg;
  assign kbd.key_pulse = pulse_reg;

endmodule

// File: tb/tb_key_debounce.sv
// ---------------------------------------------------------------------------
// tb_key_debounce -- self-checking bench for key_debounce.
// Compile with +define+KEY_REPEAT_EN to exercise the auto-repeat build.
// ---------------------------------------------------------------------------
module tb_key_debounce;

  localparam int P   = 4;  // clk per ms
  localparam int DEB = 3;  // debounce ms
  localparam int DLY = 5;  // first repeat after this many ms
  localparam int PER = 2;  // repeat period ms

  logic clk = 1'b0;
  logic rst = 1'b0;

  key_debounce_if kif();

  key_debounce #(
    .CLK_PER_MS      (P),
    .DEBOUNCE_MS     (DEB),
    .REPEAT_DELAY_MS (DLY),
    .REPEAT_PERIOD_MS(PER)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kbd(kif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Rule: the accepted level flips once key_s (key_in delayed two clocks)
  // has disagreed with it across DEBOUNCE ms ticks, counting only ticks that
  // come after the first cycle of disagreement. Pulses on acceptance of a
  // press, and (repeat build) after DLY then every PER ticks of agreeing hold.
  logic lvl_m, pulse_m, s1_m, s2_m, dis_prev;
  int   dis_ticks, hold_ticks, pre_cnt;
  bit   rep_first;

  task automatic model_reset();
    lvl_m = 0; pulse_m = 0; s1_m = 0; s2_m = 0; dis_prev = 0;
    dis_ticks = 0; hold_ticks = 0; pre_cnt = 0; rep_first = 1;
  endtask

  task automatic model_update(input logic k);
    logic tk, ks, pn;
    tk = (pre_cnt == P - 1);
    ks = s2_m;
    pn = 0;
    if (ks != lvl_m) begin
      hold_ticks = 0;
      rep_first  = 1;
      if (!dis_prev) dis_ticks = 0;
      else if (tk) begin
        dis_ticks++;
        if (dis_ticks == DEB) begin
          lvl_m = ks;
          pn = ks;
          dis_ticks = 0;
        end
      end
    end else begin
      dis_ticks = 0;
`ifdef KEY_REPEAT_EN
      if (lvl_m && !dis_prev && tk) begin
        hold_ticks++;
        if (hold_ticks == (rep_first ? DLY : PER)) begin
          pn = 1;
          hold_ticks = 0;
          rep_first = 0;
        end
      end
`endif
    end
    dis_prev = (ks != lvl_m);
    pulse_m  = pn;
    pre_cnt  = (pre_cnt + 1) % P;
    s2_m = s1_m;
    s1_m = k;
  endtask

  // ---------------- stimulus helpers ----------------
  int   pulse_cnt;
  logic obs_tick, obs_level, obs_pulse, prev_pulse;

  task automatic step(input logic k);
    @(negedge clk);
    obs_tick  = kif.ms_tick;
    obs_level = kif.key_level;
    obs_pulse = kif.key_pulse;
    chk("level", int'(obs_level), int'(lvl_m));
    chk("pulse", int'(obs_pulse), int'(pulse_m));
    chk("tick", int'(obs_tick), int'(pre_cnt == P - 1));
    chk("pulse_consec", int'(prev_pulse && obs_pulse), 0);
    prev_pulse = obs_pulse;
    if (obs_pulse) pulse_cnt++;
    kif.key_in = k;
    model_update(k);
  endtask

  // Called at a negedge.
  task automatic release_reset(input logic k);
    kif.key_in = k;
    rst = 1'b1;
    prev_pulse = 0;
    model_reset();
    model_update(k);
  endtask

  // Asserts reset mid-cycle, checks outputs drop at once, then releases.
  task automatic apply_reset(input logic k);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_tick", int'(kif.ms_tick), 0);
    chk("rst_level", int'(kif.key_level), 0);
    chk("rst_pulse", int'(kif.key_pulse), 0);
    repeat (2) @(negedge clk);
    release_reset(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, prev, lat;
    logic lvl_min;
    kif.key_in = 1'b0;
    prev_pulse = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_level", int'(kif.key_level), 0);
    chk("reset_pulse", int'(kif.key_pulse), 0);
    chk("reset_tick", int'(kif.ms_tick), 0);
    release_reset(1'b0);

    // ms_tick free-run: period P, first on the P-th cycle after release.
    first = -1; prev = 0;
    for (int i = 1; i <= 100; i++) begin
      step(1'b0);
      if (obs_tick) begin
        if (first < 0) first = i;
        else chk("tick_period", i - prev, P);
        prev = i;
      end
    end
    chk("tick_first", first, P - 1);
    $display("tick free-run: first=%0d", first);

    // Clean press, 40 clk, then release 40 clk.
    pulse_cnt = 0; lat = -1;
    step(1'b1);
    for (int d = 1; d < 40; d++) begin
      step(1'b1);
      if (obs_level && lat < 0) lat = d;
    end
    chk("press_latency_in_range", int'(lat >= 12 && lat <= 15), 1);
`ifndef KEY_REPEAT_EN
    chk("clean_press_pulses", pulse_cnt, 1);
`endif
    $display("clean press: latency=%0d pulses=%0d", lat, pulse_cnt);
    pulse_cnt = 0;
    repeat (40) step(1'b0);
    chk("release_level", int'(obs_level), 0);
`ifndef KEY_REPEAT_EN
    chk("release_pulses", pulse_cnt, 0);
`endif
    $display("clean release: pulses=%0d", pulse_cnt);

    // Press bounce: toggle every 3 clk for 30 clk, then stable.
    pulse_cnt = 0;
    for (int i = 0; i < 30; i++) step(logic'(((i / 3) % 2) == 0));
    repeat (2) step(1'b1);
    chk("bounce_pulses", pulse_cnt, 0);
    repeat (28) step(1'b1);
    chk("bounce_accept_level", int'(obs_level), 1);
`ifndef KEY_REPEAT_EN
    chk("bounce_accept_pulses", pulse_cnt, 1);
`endif
    $display("press bounce: pulses=%0d", pulse_cnt);

    // Release bounce while held: 0 for 5 clk, then 1 again.
    pulse_cnt = 0; lvl_min = 1;
    repeat (5) begin step(1'b0); lvl_min &= obs_level; end
    repeat (20) begin step(1'b1); lvl_min &= obs_level; end
    chk("rel_bounce_level", int'(lvl_min), 1);
`ifndef KEY_REPEAT_EN
    chk("rel_bounce_pulses", pulse_cnt, 0);
`endif
    $display("release bounce: level_min=%0d pulses=%0d", lvl_min, pulse_cnt);
    repeat (30) step(1'b0);

    // Reset mid-PRESS_CHK with the key held through release.
    step(1'b1);
    repeat (6) step(1'b1);
    pulse_cnt = 0;
    apply_reset(1'b1);
    repeat (30) step(1'b1);
    chk("rst_presschk_pulses", pulse_cnt, 1);
    $display("reset mid-press_chk: pulses=%0d", pulse_cnt);

    // Reset mid-HELD (key accepted above), key still held.
    pulse_cnt = 0;
    apply_reset(1'b1);
    repeat (30) step(1'b1);
    chk("rst_held_pulses", pulse_cnt, 1);
    chk("rst_held_level", int'(obs_level), 1);
    $display("reset mid-held: pulses=%0d", pulse_cnt);
    repeat (30) step(1'b0);

    // Long hold: repeats when enabled, single pulse otherwise.
    pulse_cnt = 0;
    repeat (60) step(1'b1);
`ifdef KEY_REPEAT_EN
    chk("repeat_pulses_ge3", int'(pulse_cnt >= 3), 1);
`else
    chk("hold_single_pulse", pulse_cnt, 1);
`endif
    $display("long hold: pulses=%0d", pulse_cnt);
    repeat (30) step(1'b0);

    // Randomized segments, occasionally interrupted by reset.
    for (int it = 0; it < 80; it++) begin
      logic kr;
      int   n;
      if ($urandom_range(0, 14) == 0) apply_reset(1'($urandom_range(0, 1)));
      kr = 1'($urandom_range(0, 1));
      n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 60)) : int'($urandom_range(1, 8));
      pulse_cnt = 0;
      repeat (n) step(kr);
      $display("random seg %0d: key=%0d len=%0d pulses=%0d level=%0d", it, kr, n, pulse_cnt, obs_level);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter CLK_PER_MS, default 44801, clk cycles per 1 ms tick (prescaler modulus).
REQ-002 Parameter DEBOUNCE_MS, default 10, ms of stable level required to accept a press or release.
REQ-003 Parameter REPEAT_DELAY_MS, default 500, ms of continuous hold before the first auto-repeat pulse.
REQ-004 Parameter REPEAT_PERIOD_MS, default 100, ms between subsequent auto-repeat pulses.
REQ-005 clk  input  1  sole clock; all state on posedge clk.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 key_in  input  1  raw asynchronous push-button, 1 = pressed.
REQ-008 ms_tick  output  1  one-clk pulse per ms, for downstream counter/scan logic.
REQ-009 key_level  output  1  debounced key state, 1 = pressed.
REQ-010 key_pulse  output  1  one-clk pulse per accepted press (plus repeats when enabled), feeds the BCD counter's increment.

Function
REQ-011 key_in SHALL pass a 2-flop synchronizer; key_s is the second flop; FSM sees key_in 2 clk late.
REQ-012 Prescaler SHALL count 0..CLK_PER_MS-1 and wrap; ms_tick SHALL be 1 exactly on the cycle the count equals CLK_PER_MS-1.
REQ-013 FSM states SHALL be IDLE, PRESS_CHK, HELD, REL_CHK; ms counter ms_cnt, width $clog2(max(DEBOUNCE_MS,REPEAT_DELAY_MS)+1).
REQ-014 IDLE: key_s=1 SHALL go PRESS_CHK with ms_cnt=0; else stay.
REQ-015 PRESS_CHK: key_s=0 SHALL return to IDLE (bounce rejected, no pulse); each ms_tick with key_s=1 SHALL increment ms_cnt.
REQ-016 PRESS_CHK: on the ms_tick that makes ms_cnt reach DEBOUNCE_MS, SHALL go HELD, set key_level=1 and assert key_pulse that same next cycle for exactly one clk; ms_cnt cleared.
REQ-017 HELD: key_s=0 SHALL go REL_CHK with ms_cnt=0; key_level stays 1.
REQ-018 REL_CHK: key_s=1 SHALL return to HELD (no new pulse, repeat timer restarted); DEBOUNCE_MS ticks with key_s=0 SHALL go IDLE and clear key_level.
REQ-019 Simultaneous ms_tick and key_s change: key_s change SHALL win (counter cleared, state per REQ-015/018).
REQ-020 key_pulse SHALL never be high for two consecutive cycles and SHALL only assert in transition to HELD or per REQ-025.
REQ-021 Latency raw press (stable) to key_pulse: 2 clk sync + DEBOUNCE_MS ticks (first tick partial) + 1 clk.

Reset
REQ-022 rst=0 SHALL immediately force state IDLE, ms_cnt=0, prescaler=0, sync flops=0, ms_tick=0, key_level=0, key_pulse=0.
REQ-023 Reset asserted mid-PRESS_CHK or HELD SHALL emit no pulse; after release a key still held SHALL be re-debounced from IDLE and produce one pulse.
REQ-024 Reset release SHALL be usable synchronously on the next posedge; no output glitch on release.

Configuration
REQ-025 Macro KEY_REPEAT_EN defined: in HELD, ms_cnt counts ticks; at REPEAT_DELAY_MS one key_pulse, then one every REPEAT_PERIOD_MS while held; REL_CHK bounce back to HELD restarts from REPEAT_DELAY_MS.
REQ-026 KEY_REPEAT_EN undefined: exactly one key_pulse per press regardless of hold time; repeat counters absent from netlist.

Structure
REQ-027 Package key_pkg SHALL hold the FSM state enum and default timing constants (CLK_PER_MS, DEBOUNCE_MS, repeat values).
REQ-028 Prescaler SHALL be sub-module ms_tick_gen (parameter CLK_PER_MS; ports clk, rst, ms_tick); key_debounce instantiates one.

Verification (CLK_PER_MS=4, DEBOUNCE_MS=3, REPEAT_DELAY_MS=5, REPEAT_PERIOD_MS=2)
REQ-029 Clean press held 40 clk -> exactly one key_pulse, key_level=1 ~14 clk after press edge; release 40 clk -> key_level=0, no pulse.
REQ-030 Bounce: key_in toggles every 3 clk for 30 clk then stays 1 -> no pulse during bounce, one pulse after 3 stable ticks.
REQ-031 Release bounce: while HELD, key_in 0 for 5 clk then 1 -> key_level stays 1, no extra pulse.
REQ-032 rst=0 asserted mid-PRESS_CHK and mid-HELD -> all outputs 0 asynchronously; key held through release -> one pulse after re-debounce.
REQ-033 KEY_REPEAT_EN, hold 60 clk -> pulses at acceptance, +5 ticks, then every 2 ticks; undefined -> single pulse.
REQ-034 ms_tick free-run 100 clk -> period exactly 4 clk, width 1 clk, first at clk 4 after reset release.
